f_bpred: RTL and testbench

F_BPRED -- requirements
Module: f_bpred

---
 rtl/f_bpred.sv | 145 ++++++++++++++
 tb/tb_f_bpred.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_bpred.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : f_bpred                                                      |
// | Description : Fetch-stage branch target predictor. A direct-mapped table   |
// |               of {valid, 2-bit counter, tag, target} entries is cleared    |
// |               by a sweep after reset, then serves one-cycle lookups and    |
// |               accepts execute-stage updates with write-first bypass.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module f_bpred #(
    parameter int IDX_W = 11,
    parameter int PC_W  = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_en,
    input  logic [PC_W-1:0]               rd_pc,
    input  logic                          wen,
    input  logic [IDX_W-1:0]              w_addr,
    input  logic [3+(PC_W-IDX_W)+PC_W-1:0] w_data,
    output logic                          ready,
    output logic                          pred_valid,
    output logic [PC_W-1:0]               pc_predicted,
    output logic                          pred_taken
);

    localparam int c_TAG_W = PC_W - IDX_W;
    localparam int c_ENT_W = 3 + c_TAG_W + PC_W;
    localparam int c_DEPTH = 1 << IDX_W;

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [IDX_W-1:0]   r_clr_cnt;

    logic [c_ENT_W-1:0] r_mem [0:c_DEPTH-1];
    logic               w_mem_we;
    logic [IDX_W-1:0]   w_mem_addr;
    logic [c_ENT_W-1:0] w_mem_wdata;

    logic               w_lookup;
    logic               w_bypass;
    logic [c_ENT_W-1:0] r_rd_data;
    logic [PC_W-1:0]    r_rd_pc;
    logic               r_pred_vld;
    logic               r_has_pred;

    logic               w_ent_valid;
    logic               w_ent_strong;
    logic [c_TAG_W-1:0] w_ent_tag;
    logic [PC_W-1:0]    w_ent_target;
    logic               w_hit;

    // State register: reset always restarts the clear sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and table write-port steering (sweep owns the port in INIT)
    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_addr  = w_addr;
        w_mem_wdata = w_data;
        case (r_state)
            c_ST_INIT: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_cnt;
                w_mem_wdata = '0;
                if (r_clr_cnt == {IDX_W{1'b1}}) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_mem_we    = wen;
            end
            default: begin
                w_state_nxt = c_ST_INIT;
            end
        endcase
    end

    // Clear counter walks every index once while initialising
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Table storage write port (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign w_lookup = (r_state == c_ST_RUN) && rd_en;
    assign w_bypass = wen && (w_addr == rd_pc[IDX_W-1:0]);

    // Synchronous read port; a same-index update is forwarded so the lookup sees new data
    always_ff @(posedge clk) begin
        if (w_lookup) begin
            r_rd_data <= w_bypass ? w_data : r_mem[rd_pc[IDX_W-1:0]];
        end
    end

    // Lookup PC and valid tracking; r_has_pred keeps outputs at zero until the first lookup
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pc    <= '0;
            r_pred_vld <= 1'b0;
            r_has_pred <= 1'b0;
        end else begin
            r_pred_vld <= w_lookup;
            if (w_lookup) begin
                r_rd_pc    <= rd_pc;
                r_has_pred <= 1'b1;
            end
        end
    end

    assign w_ent_valid  = r_rd_data[c_ENT_W-1];
    assign w_ent_strong = r_rd_data[c_ENT_W-2];
    assign w_ent_tag    = r_rd_data[PC_W +: c_TAG_W];
    assign w_ent_target = r_rd_data[PC_W-1:0];
    assign w_hit        = w_ent_valid && w_ent_strong &&
                          (w_ent_tag == r_rd_pc[PC_W-1 -: c_TAG_W]);

    assign ready        = (r_state == c_ST_RUN);
    assign pred_valid   = r_pred_vld;
    assign pred_taken   = r_has_pred && w_hit;
    assign pc_predicted = !r_has_pred ? '0 :
                          w_hit       ? w_ent_target :
                                        r_rd_pc + PC_W'(1);

endmodule
`default_nettype wire

// File: tb/tb_f_bpred.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_f_bpred                                                   |
// | Description : Directed self-checking bench for the f_bpred predictor.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_f_bpred;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [12:0] rd_pc;
    logic        wen;
    logic [10:0] w_addr;
    logic [17:0] w_data;
    logic        ready;
    logic        pred_valid;
    logic [12:0] pc_predicted;
    logic        pred_taken;

    int checks;
    int failures;

    f_bpred u_dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .rd_pc        (rd_pc),
        .wen          (wen),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .ready        (ready),
        .pred_valid   (pred_valid),
        .pc_predicted (pc_predicted),
        .pred_taken   (pred_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers (called at posedge+1, return at posedge+1)
    task automatic lookup(input logic [12:0] pc);
        rd_en = 1'b1;
        rd_pc = pc;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic write_entry(input logic [10:0] addr, input logic [17:0] data);
        wen    = 1'b1;
        w_addr = addr;
        w_data = data;
        @(posedge clk);
        #1;
        wen = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || pred_valid !== 1'b0 || pred_taken !== 1'b0 || pc_predicted !== 13'h0000) begin
            failures++;
            $display("FAIL reset_state: ready=%b pv=%b taken=%b pc=%h required 0/0/0/0000",
                     ready, pred_valid, pred_taken, pc_predicted);
        end
    endtask

    task automatic test_init;
        int n;
        logic seen_pv;
        n = 0;
        seen_pv = 1'b0;
        rst = 1'b0;
        while (!ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (pred_valid) seen_pv = 1'b1;
            if (n == 100) begin
                wen    = 1'b1;
                w_addr = 11'h007;
                w_data = 18'h3FFFF;
                rd_en  = 1'b1;
                rd_pc  = 13'h1807;
            end else if (n == 101) begin
                wen   = 1'b0;
                rd_en = 1'b0;
            end
        end
        checks++;
        if (n !== 2048) begin
            failures++;
            $display("FAIL init_latency: ready after %0d cycles, required 2048", n);
        end
        checks++;
        if (seen_pv !== 1'b0) begin
            failures++;
            $display("FAIL init_no_pred: pred_valid=%b during INIT, required 0", seen_pv);
        end
        lookup(13'h1807);
        checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pc_predicted !== 13'h1808) begin
            failures++;
            $display("FAIL init_wen_ignored: pv=%b taken=%b pc=%h required 1/0/1808",
                     pred_valid, pred_taken, pc_predicted);
        end
    endtask

    task automatic test_empty_lookup;
        lookup(13'h0005);
        checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pc_predicted !== 13'h0006) begin
            failures++;
            $display("FAIL empty_lookup: pv=%b taken=%b pc=%h required 1/0/0006",
                     pred_valid, pred_taken, pc_predicted);
        end
    endtask

    task automatic test_hit_and_tag;
        write_entry(11'h005, {1'b1, 2'b10, 2'b00, 13'h0040});
        lookup(13'h0005);
        checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pc_predicted !== 13'h0040) begin
            failures++;
            $display("FAIL hit: pv=%b taken=%b pc=%h required 1/1/0040",
                     pred_valid, pred_taken, pc_predicted);
        end
        lookup(13'h0805);
        checks++;
        if (pred_taken !== 1'b0 || pc_predicted !== 13'h0806) begin
            failures++;
            $display("FAIL tag_mismatch: taken=%b pc=%h required 0/0806", pred_taken, pc_predicted);
        end
    endtask

    task automatic test_hold;
        @(posedge clk);
        #1;
        checks++;
        if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pc_predicted !== 13'h0806) begin
            failures++;
            $display("FAIL hold: pv=%b taken=%b pc=%h required 0/0/0806",
                     pred_valid, pred_taken, pc_predicted);
        end
    endtask

    task automatic test_weak_and_wrap;
        write_entry(11'h005, {1'b1, 2'b01, 2'b00, 13'h0040});
        lookup(13'h0005);
        checks++;
        if (pred_taken !== 1'b0 || pc_predicted !== 13'h0006) begin
            failures++;
            $display("FAIL weak_state: taken=%b pc=%h required 0/0006", pred_taken, pc_predicted);
        end
        lookup(13'h1FFF);
        checks++;
        if (pred_taken !== 1'b0 || pc_predicted !== 13'h0000) begin
            failures++;
            $display("FAIL pc_wrap: taken=%b pc=%h required 0/0000", pred_taken, pc_predicted);
        end
        write_entry(11'h030, {1'b0, 2'b11, 2'b00, 13'h0111});
        lookup(13'h0030);
        checks++;
        if (pred_taken !== 1'b0 || pc_predicted !== 13'h0031) begin
            failures++;
            $display("FAIL invalid_entry: taken=%b pc=%h required 0/0031", pred_taken, pc_predicted);
        end
    endtask

    task automatic test_bypass;
        wen    = 1'b1;
        w_addr = 11'h010;
        w_data = {1'b1, 2'b11, 2'b00, 13'h0123};
        lookup(13'h0010);
        wen = 1'b0;
        checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pc_predicted !== 13'h0123) begin
            failures++;
            $display("FAIL bypass: pv=%b taken=%b pc=%h required 1/1/0123",
                     pred_valid, pred_taken, pc_predicted);
        end
        lookup(13'h0010);
        checks++;
        if (pred_taken !== 1'b1 || pc_predicted !== 13'h0123) begin
            failures++;
            $display("FAIL bypass_stored: taken=%b pc=%h required 1/0123", pred_taken, pc_predicted);
        end
    endtask

    task automatic test_independent_rw;
        wen    = 1'b1;
        w_addr = 11'h020;
        w_data = {1'b1, 2'b11, 2'b00, 13'h0ABC};
        lookup(13'h0005);
        wen = 1'b0;
        checks++;
        if (pred_taken !== 1'b0 || pc_predicted !== 13'h0006) begin
            failures++;
            $display("FAIL indep_read: taken=%b pc=%h required 0/0006", pred_taken, pc_predicted);
        end
        lookup(13'h0020);
        checks++;
        if (pred_taken !== 1'b1 || pc_predicted !== 13'h0ABC) begin
            failures++;
            $display("FAIL indep_write: taken=%b pc=%h required 1/0ABC", pred_taken, pc_predicted);
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] pcs [3];
        logic [12:0] exp_pc [3];
        logic        exp_tk [3];
        pcs[0] = 13'h0010; exp_pc[0] = 13'h0123; exp_tk[0] = 1'b1;
        pcs[1] = 13'h0005; exp_pc[1] = 13'h0006; exp_tk[1] = 1'b0;
        pcs[2] = 13'h0020; exp_pc[2] = 13'h0ABC; exp_tk[2] = 1'b1;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_pc = pcs[i];
            @(posedge clk);
            #1;
            checks++;
            if (pred_valid !== 1'b1 || pred_taken !== exp_tk[i] || pc_predicted !== exp_pc[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d]: pv=%b taken=%b pc=%h required 1/%b/%h",
                         i, pred_valid, pred_taken, pc_predicted, exp_tk[i], exp_pc[i]);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int n;
        lookup(13'h0010);
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || pred_valid !== 1'b0 || pred_taken !== 1'b0 || pc_predicted !== 13'h0000) begin
            failures++;
            $display("FAIL run_reset_async: ready=%b pv=%b taken=%b pc=%h required 0/0/0/0000",
                     ready, pred_valid, pred_taken, pc_predicted);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL init_reset_ready: ready=%b required 0", ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(n);
        checks++;
        if (n !== 2048) begin
            failures++;
            $display("FAIL reinit_latency: ready after %0d cycles, required 2048", n);
        end
        lookup(13'h0010);
        checks++;
        if (pred_taken !== 1'b0 || pc_predicted !== 13'h0011) begin
            failures++;
            $display("FAIL reinit_miss_10: taken=%b pc=%h required 0/0011", pred_taken, pc_predicted);
        end
        lookup(13'h0020);
        checks++;
        if (pred_taken !== 1'b0 || pc_predicted !== 13'h0021) begin
            failures++;
            $display("FAIL reinit_miss_20: taken=%b pc=%h required 0/0021", pred_taken, pc_predicted);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rd_en    = 1'b0;
        rd_pc    = '0;
        wen      = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        test_reset();
        test_init();
        test_empty_lookup();
        test_hit_and_tag();
        test_hold();
        test_weak_and_wrap();
        test_bypass();
        test_independent_rw();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
